c_deskew: RTL

Output-side deskew buffer for the systolic matrix-multiply datapath. It is the read-out counterpart to the B-operand skew buffer. The array emits result rows on a diagonal wavefront: row r lags row 0 by r beats. This block delays each row so that every column of the result tile leaves as one aligned DIM-wide vector, with a valid strobe, a column index and an end-of-tile pulse for the downstream result writer.

---
 rtl/systolic_pkg.sv | 11 +
 rtl/delay_line.sv | 27 ++
 rtl/c_deskew.sv | 67 ++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared enums and default sizes for the systolic matrix-multiply datapath
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FILL, EMIT} c_deskew_state_t;
  localparam int BITS_AB = 8;
  localparam int BITS_C = 24;
  localparam int DIM = 8;
  localparam int TILE_LEN = 2 * DIM - 1;
  function automatic int tile_len(input int dim);
    return 2 * dim - 1;
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: beat-enabled shift register of DEPTH stages; DEPTH=0 is a wire
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk ^ en;
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];
      // shift one stage per beat; contents need no reset since every tile refills them
      always_ff @(posedge clk)
        if (en) begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      assign q = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/c_deskew.sv
// c_deskew: realigns the diagonal result wavefront into one column per beat; DESKEW_ZERO_GATE_EN zeroes Cout when idle
module c_deskew #(
  parameter int BITS_C = systolic_pkg::BITS_C,
  parameter int DIM = systolic_pkg::DIM,
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [BITS_C-1:0] Cin [DIM],
  output logic                     out_valid,
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic [IW-1:0]            col_idx,
  output logic                     tile_done
);
  import systolic_pkg::*;
  localparam int LAST = tile_len(DIM) - 1;
  localparam int CW = $clog2(LAST + 2);
  logic [CW-1:0] cnt, cnt_n;
  c_deskew_state_t state, state_n;
  logic emit;
  logic [IW-1:0] col;
  logic signed [BITS_C-1:0] aligned [DIM];
  // state tracks where the counter sits in the tile; DIM=1 makes every beat an emitting beat
  always_comb begin
    cnt_n = (cnt == CW'(LAST)) ? '0 : cnt + 1'b1;
    state_n = (cnt_n == '0) ? IDLE : (cnt_n >= CW'(DIM - 1)) ? EMIT : FILL;
    emit = in_valid && (state == EMIT || (state == IDLE && DIM == 1));
    col = IW'(cnt - CW'(DIM - 1));
  end
  // beat counter and FSM advance only on beats
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      state <= IDLE;
    end else if (in_valid) begin
      cnt <= cnt_n;
      state <= state_n;
    end
  for (genvar g = 0; g < DIM; g++) begin : g_row
    delay_line #(.DEPTH(DIM - 1 - g), .WIDTH(BITS_C)) u_dl (
      .clk(clk),
      .en(in_valid),
      .d(Cin[g]),
      .q(aligned[g])
    );
  end
  // output register captures one aligned column per emitting beat
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      tile_done <= 1'b0;
      col_idx <= '0;
      for (int r = 0; r < DIM; r++) Cout[r] <= '0;
    end else begin
      out_valid <= emit;
      tile_done <= emit && col == IW'(DIM - 1);
      if (emit) begin
        col_idx <= col;
        for (int r = 0; r < DIM; r++) Cout[r] <= aligned[r];
      end
`ifdef DESKEW_ZERO_GATE_EN
      else for (int r = 0; r < DIM; r++) Cout[r] <= '0;
`else
`endif
    end
endmodule
